// File: rtl/seq_bus_datapath.sv
// seq_bus_datapath: single-bus register/ALU datapath with its own start/done micro-sequencer
module seq_bus_datapath #(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 16,
  localparam int RA_W = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [RA_W-1:0]   dst,
  input  logic [RA_W-1:0]   src_a,
  input  logic [RA_W-1:0]   src_b,
  input  logic              ld_en,
  input  logic [RA_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [RA_W-1:0]   rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] bus,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              busy,
  output logic              done
);
  localparam int ZW = 2 * DATA_W;
  localparam int SW = $clog2(DATA_W);
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_SHL = 3'd4, OP_SHR = 3'd5, OP_MUL = 3'd6, OP_MOV = 3'd7;
  typedef enum logic [2:0] {IDLE, LDY, CALC, WB, WHI} state_t;
  state_t state;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] y, hi, lo, res;
  logic [ZW-1:0] z, alu_z;
  logic [2:0] op_q;
  logic [RA_W-1:0] dst_q, sa_q, sb_q;
  assign rd_data = regs[rd_addr];
  assign hi_out = hi;
  assign lo_out = lo;
  // exactly one bus driver per state; MOV bypasses the ALU and reuses src_a in WB
  always_comb begin
    bus = state == LDY  ? regs[sa_q] :
          state == CALC ? regs[sb_q] :
          state == WB   ? (op_q == OP_MOV ? regs[sa_q] : z[DATA_W-1:0]) :
          state == WHI  ? z[ZW-1:DATA_W] : '0;
  end
  always_comb begin
    res = '0;
    case (op_q)
      OP_ADD: res = y + bus;
      OP_SUB: res = y - bus;
      OP_AND: res = y & bus;
      OP_OR:  res = y | bus;
      OP_SHL: res = y << bus[SW-1:0];
      OP_SHR: res = y >> bus[SW-1:0];
      default: res = '0;
    endcase
    alu_z = op_q == OP_MUL ? ZW'(y) * ZW'(bus) : {{DATA_W{1'b0}}, res};
  end
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
      y <= '0;
      z <= '0;
      hi <= '0;
      lo <= '0;
      op_q <= '0;
      dst_q <= '0;
      sa_q <= '0;
      sb_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            dst_q <= dst;
            sa_q <= src_a;
            sb_q <= src_b;
            busy <= 1'b1;
            state <= op == OP_MOV ? WB : LDY;
          end else if (ld_en) begin
            regs[ld_addr] <= ld_data;
          end
        end
        LDY: begin
          y <= bus;
          state <= CALC;
        end
        CALC: begin
          z <= alu_z;
          state <= WB;
        end
        WB: begin
          if (op_q == OP_MUL) begin
            lo <= bus;
            state <= WHI;
          end else begin
            regs[dst_q] <= bus;
            busy <= 1'b0;
            done <= 1'b1;
            state <= IDLE;
          end
        end
        WHI: begin
          hi <= bus;
          busy <= 1'b0;
          done <= 1'b1;
          state <= IDLE;
        end
        default: begin
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_bus_datapath.sv
// tb_seq_bus_datapath: directed vector table plus hand sequences for seq_bus_datapath
module tb_seq_bus_datapath;
  logic clock = 1'b0, clear = 1'b1;
  logic start = 1'b0, ld_en = 1'b0;
  logic [2:0] op = '0;
  logic [3:0] dst = '0, src_a = '0, src_b = '0, ld_addr = '0, rd_addr = '0;
  logic [31:0] ld_data = '0, rd_data, bus, hi_out, lo_out;
  logic busy, done;
  logic p_start = 1'b0, p_ld_en = 1'b0;
  logic [2:0] p_op = '0;
  logic [1:0] p_dst = '0, p_sa = '0, p_sb = '0, p_ld_addr = '0, p_rd_addr = '0;
  logic [15:0] p_ld_data = '0, p_rd_data, p_bus, p_hi, p_lo;
  logic p_busy, p_done;
  int n_cmp = 0, n_err = 0;

  always #5 clock = ~clock;

  seq_bus_datapath dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .dst(dst), .src_a(src_a),
    .src_b(src_b), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .bus(bus), .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done)
  );

  seq_bus_datapath #(.DATA_W(16), .NUM_REGS(4)) dut16 (
    .clock(clock), .clear(clear), .start(p_start), .op(p_op), .dst(p_dst), .src_a(p_sa),
    .src_b(p_sb), .ld_en(p_ld_en), .ld_addr(p_ld_addr), .ld_data(p_ld_data),
    .rd_addr(p_rd_addr), .rd_data(p_rd_data), .bus(p_bus), .hi_out(p_hi), .lo_out(p_lo),
    .busy(p_busy), .done(p_done)
  );

  typedef struct {
    logic [2:0] op;
    logic [3:0] d, a, b;
    logic [31:0] va, vb, exp;
  } vec_t;
  vec_t tv [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [31:0] v);
    ld_en = 1'b1;
    ld_addr = a;
    ld_data = v;
    step();
    ld_en = 1'b0;
  endtask

  // cyc = edges after acceptance until done is seen; nb = samples with busy high
  task automatic run_op(input logic [2:0] o, input logic [3:0] d, a, b, input bit poke,
                        output int cyc, output int nb);
    start = 1'b1;
    op = o;
    dst = d;
    src_a = a;
    src_b = b;
    step();
    start = 1'b0;
    ld_en = 1'b0;
    cyc = 0;
    nb = 0;
    while (!done && cyc < 20) begin
      if (busy) nb++;
      if (poke && cyc == 0) begin
        start = 1'b1;
        op = 3'd7;
        dst = 4'd15;
        src_a = 4'd1;
      end else begin
        start = 1'b0;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    if (!done) begin
      n_err++;
      $display("FAIL timeout: op %0d no done within %0d cycles", o, cyc);
    end
  endtask

  initial begin
    int cyc, nb, dn;
    tv[0] = '{3'd0, 4'd3,  4'd1, 4'd2,  32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0004};
    tv[1] = '{3'd1, 4'd8,  4'd9, 4'd10, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE};
    tv[2] = '{3'd2, 4'd4,  4'd9, 4'd10, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200};
    tv[3] = '{3'd3, 4'd5,  4'd9, 4'd10, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F};
    tv[4] = '{3'd4, 4'd8,  4'd6, 4'd7,  32'h8000_0001, 32'h0000_0021, 32'h0000_0002};
    tv[5] = '{3'd5, 4'd8,  4'd6, 4'd7,  32'h8000_0001, 32'h0000_0021, 32'h4000_0000};
    tv[6] = '{3'd0, 4'd11, 4'd11, 4'd12, 32'h0000_0007, 32'h0000_0009, 32'h0000_0010};
    tv[7] = '{3'd4, 4'd12, 4'd6, 4'd7,  32'h0000_0001, 32'h0000_00FF, 32'h8000_0000};
    tv[8] = '{3'd1, 4'd1,  4'd1, 4'd1,  32'h0000_1234, 32'h0000_1234, 32'h0000_0000};
    #3 clear = 1'b0;
    step();
    step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_bus", 64'(bus), 64'd0);
    chk("rst_hi", 64'(hi_out), 64'd0);
    chk("rst_lo", 64'(lo_out), 64'd0);
    chk("rst_r0", 64'(rd_data), 64'd0);
    clear = 1'b1;
    step();
    for (int i = 0; i < 9; i++) begin
      load(tv[i].a, tv[i].va);
      if (tv[i].b != tv[i].a) load(tv[i].b, tv[i].vb);
      rd_addr = tv[i].d;
      run_op(tv[i].op, tv[i].d, tv[i].a, tv[i].b, 1'b0, cyc, nb);
      chk($sformatf("v%0d_res", i), 64'(rd_data), 64'(tv[i].exp));
      chk($sformatf("v%0d_cyc", i), 64'(cyc), 64'd3);
      chk($sformatf("v%0d_busy", i), 64'(nb), 64'd3);
      step();
      chk($sformatf("v%0d_done1", i), 64'(done), 64'd0);
    end
    // MUL: LO then HI, no register write
    load(4'd4, 32'hFFFF_FFFF);
    load(4'd5, 32'h0000_0002);
    load(4'd13, 32'hAAAA_AAAA);
    start = 1'b1; op = 3'd6; dst = 4'd13; src_a = 4'd4; src_b = 4'd5;
    step();
    start = 1'b0;
    chk("mul_bus_a", 64'(bus), 64'hFFFF_FFFF);
    step();
    chk("mul_bus_b", 64'(bus), 64'h0000_0002);
    step();
    chk("mul_bus_zl", 64'(bus), 64'hFFFF_FFFE);
    step();
    chk("mul_lo", 64'(lo_out), 64'hFFFF_FFFE);
    chk("mul_hi_early", 64'(hi_out), 64'd0);
    chk("mul_done_early", 64'(done), 64'd0);
    chk("mul_bus_zh", 64'(bus), 64'h0000_0001);
    step();
    chk("mul_hi", 64'(hi_out), 64'h0000_0001);
    chk("mul_done", 64'(done), 64'd1);
    chk("mul_busy", 64'(busy), 64'd0);
    rd_addr = 4'd13;
    #1 chk("mul_no_rwrite", 64'(rd_data), 64'hAAAA_AAAA);
    // start while busy is dropped, not queued
    load(4'd1, 32'h0000_0005);
    load(4'd2, 32'hFFFF_FFFF);
    rd_addr = 4'd14;
    run_op(3'd0, 4'd14, 4'd1, 4'd2, 1'b1, cyc, nb);
    chk("col_res", 64'(rd_data), 64'h0000_0004);
    chk("col_cyc", 64'(cyc), 64'd3);
    step();
    chk("col_not_queued", 64'(busy), 64'd0);
    rd_addr = 4'd15;
    #1 chk("col_r15", 64'(rd_data), 64'd0);
    // load together with start: start wins
    ld_en = 1'b1; ld_addr = 4'd15; ld_data = 32'hDEAD_BEEF;
    rd_addr = 4'd1;
    run_op(3'd1, 4'd1, 4'd1, 4'd1, 1'b0, cyc, nb);
    chk("inplace_sub", 64'(rd_data), 64'd0);
    rd_addr = 4'd15;
    #1 chk("ld_dropped", 64'(rd_data), 64'd0);
    rd_addr = 4'd9;
    run_op(3'd7, 4'd9, 4'd2, 4'd0, 1'b0, cyc, nb);
    chk("mov_res", 64'(rd_data), 64'hFFFF_FFFF);
    chk("mov_cyc", 64'(cyc), 64'd1);
    // back-to-back: second start accepted while done is high
    load(4'd11, 32'd3);
    load(4'd12, 32'd4);
    run_op(3'd0, 4'd10, 4'd11, 4'd12, 1'b0, cyc, nb);
    run_op(3'd1, 4'd8, 4'd12, 4'd11, 1'b0, cyc, nb);
    chk("b2b_cyc", 64'(cyc), 64'd3);
    rd_addr = 4'd10;
    #1 chk("b2b_r10", 64'(rd_data), 64'd7);
    rd_addr = 4'd8;
    #1 chk("b2b_r8", 64'(rd_data), 64'd1);
    // reset at k+2 of a MUL aborts everything
    start = 1'b1; op = 3'd6; dst = 4'd13; src_a = 4'd4; src_b = 4'd5;
    step();
    start = 1'b0;
    step();
    step();
    rd_addr = 4'd4;
    clear = 1'b0;
    #1;
    chk("abort_hi", 64'(hi_out), 64'd0);
    chk("abort_lo", 64'(lo_out), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_bus", 64'(bus), 64'd0);
    chk("abort_r4", 64'(rd_data), 64'd0);
    step();
    clear = 1'b1;
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done) dn++;
    end
    chk("abort_no_done", 64'(dn), 64'd0);
    // 16-bit / 4-register instance
    p_ld_en = 1'b1; p_ld_addr = 2'd1; p_ld_data = 16'hFFFF;
    step();
    p_ld_addr = 2'd2; p_ld_data = 16'h0001;
    step();
    p_ld_addr = 2'd0; p_ld_data = 16'h1234;
    step();
    p_ld_en = 1'b0;
    p_start = 1'b1; p_op = 3'd0; p_dst = 2'd3; p_sa = 2'd1; p_sb = 2'd2;
    step();
    p_start = 1'b0;
    cyc = 0;
    while (!p_done && cyc < 20) begin step(); cyc++; end
    p_rd_addr = 2'd3;
    #1;
    chk("p16_add_cyc", 64'(cyc), 64'd3);
    chk("p16_add_res", 64'(p_rd_data), 64'h0000);
    p_start = 1'b1; p_op = 3'd7; p_dst = 2'd3; p_sa = 2'd0;
    step();
    p_start = 1'b0;
    cyc = 0;
    while (!p_done && cyc < 20) begin step(); cyc++; end
    chk("p16_mov_cyc", 64'(cyc), 64'd1);
    chk("p16_mov_res", 64'(p_rd_data), 64'h1234);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
